lcd8080_rx: RTL and testbench

- Display-side responder for the bit-banged 8080-style parallel LCD bus driven by the AHB LCD register block (CS/RS/WR/RD/RST/DATA).
- Decodes a small ILI9341-compatible command subset: window set, memory write, display on/off, software reset, read ID.
- Streams pixel writes into a framebuffer write port.
- Used as the on-chip panel model for system simulation and as the front end of the FPGA framebuffer display path.

---
 rtl/lcd8080_rx_if.sv | 25 ++
 rtl/lcd8080_rx.sv | 246 ++++++++++++++++++++++++
 tb/tb_lcd8080_rx.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd8080_rx_if.sv
// 8080-style parallel LCD bus between a bit-banging host and the panel responder.
// Latency: none, this is wiring only.
// Backpressure: none. The host paces the bus with its own strobes.
interface lcd8080_rx_if;
    logic        LCD_CS;
    logic        LCD_RS;
    logic        LCD_WR;
    logic        LCD_RD;
    logic        LCD_RST;
    logic [15:0] LCD_DATA_I;
    logic [15:0] LCD_DATA_O;
    logic        LCD_DATA_OE;

    // Host side: drives the strobes and write data, receives read data.
    modport master (
        output LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_DATA_I,
        input  LCD_DATA_O, LCD_DATA_OE
    );

    // Panel side: samples the strobes and write data, returns read data.
    modport slave (
        input  LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_DATA_I,
        output LCD_DATA_O, LCD_DATA_OE
    );
endinterface

// File: rtl/lcd8080_rx.sv
// ILI9341-subset panel responder: decodes 8080 bus cycles and streams pixels into a framebuffer.
// Latency: FB_WE rises 4 HCLK edges after the first edge that samples LCD_WR high; CMD_ERR one edge earlier.
// Backpressure: none. The framebuffer port must accept one write per bus cycle; the bus has no wait states.
module lcd8080_rx #(
    parameter int          H_RES    = 240,
    parameter int          V_RES    = 320,
    parameter int          ADDR_W   = 17,
    parameter logic [15:0] ID_VALUE = 16'h9341
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    lcd8080_rx_if.slave       bus,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [15:0]       FB_WDATA,
    output logic              DISP_ON,
    output logic              CMD_ERR
);

    localparam logic [16:0]       H_LIM   = 17'(H_RES);
    localparam logic [16:0]       V_LIM   = 17'(V_RES);
    localparam logic [15:0]       EC_DEF  = 16'(H_RES - 1);
    localparam logic [15:0]       EP_DEF  = 16'(V_RES - 1);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_RDID
    } state_t;

    // Synchronizer chains; index 1 is the synchronized value.
    logic [1:0]  cs_sy, rs_sy, wr_sy, rd_sy, rst_sy;
    logic [15:0] dat_s1, dat_s2;
    logic        wr_q, rd_q;
    logic        cs_s, rs_s, wr_s, rd_s, rst_s;
    logic        local_rst;
    logic        wr_rise, rd_fall, rd_rise;

    // Registered bus events, one cycle after detection.
    logic        ev_wr, ev_rd_rise, ev_err, ev_rs;
    logic [15:0] ev_dat;

    // Controller state.
    state_t            state;
    logic [1:0]        par_cnt;
    logic [23:0]       par_buf;
    logic [15:0]       sc, ec, sp, ep;
    logic [15:0]       cur_x, cur_y;
    logic [2:0]        id_idx;
    logic              px_vld;
    logic [ADDR_W-1:0] px_addr;
    logic [15:0]       px_dat;

    logic [15:0] p_start, p_end;
    logic        col_ok, row_ok;
    logic [15:0] rd_word;

    // Bring every bus line into the HCLK domain and keep the previous WR/RD for edge detection.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cs_sy  <= 2'b11;
            rs_sy  <= 2'b00;
            wr_sy  <= 2'b11;
            rd_sy  <= 2'b11;
            rst_sy <= 2'b11;
            dat_s1 <= '0;
            dat_s2 <= '0;
            wr_q   <= 1'b1;
            rd_q   <= 1'b1;
        end else begin
            cs_sy  <= {cs_sy[0],  bus.LCD_CS};
            rs_sy  <= {rs_sy[0],  bus.LCD_RS};
            wr_sy  <= {wr_sy[0],  bus.LCD_WR};
            rd_sy  <= {rd_sy[0],  bus.LCD_RD};
            rst_sy <= {rst_sy[0], bus.LCD_RST};
            dat_s1 <= bus.LCD_DATA_I;
            dat_s2 <= dat_s1;
            wr_q   <= wr_sy[1];
            rd_q   <= rd_sy[1];
        end
    end

    assign cs_s  = cs_sy[1];
    assign rs_s  = rs_sy[1];
    assign wr_s  = wr_sy[1];
    assign rd_s  = rd_sy[1];
    assign rst_s = rst_sy[1];

    // Panel reset behaves like system reset for everything past the synchronizers,
    // so a strobe edge coinciding with either reset is simply lost.
    assign local_rst = !HRESETn || !rst_s;

    assign wr_rise = !cs_s &&  wr_s && !wr_q;
    assign rd_fall = !cs_s && !rd_s &&  rd_q;
    assign rd_rise = !cs_s &&  rd_s && !rd_q;

    // Register qualified events; overlapping WR and RD strobes become an error instead of an access.
    always_ff @(posedge HCLK) begin
        if (local_rst) begin
            ev_wr      <= 1'b0;
            ev_rd_rise <= 1'b0;
            ev_err     <= 1'b0;
            ev_rs      <= 1'b0;
            ev_dat     <= '0;
        end else begin
            ev_wr      <= wr_rise && rd_s;
            ev_rd_rise <= rd_rise && wr_s;
            ev_err     <= (wr_rise && !rd_s) || ((rd_fall || rd_rise) && !wr_s);
            ev_rs      <= rs_s;
            ev_dat     <= dat_s2;
        end
    end

    // Window parameters: the first three bytes sit in par_buf, the fourth is on the bus now.
    assign p_start = par_buf[23:8];
    assign p_end   = {par_buf[7:0], ev_dat[7:0]};
    assign col_ok  = (p_start <= p_end) && ({1'b0, p_end} < H_LIM);
    assign row_ok  = (p_start <= p_end) && ({1'b0, p_end} < V_LIM);

    // Command decoder, window registers, pixel cursor and read-ID index.
    always_ff @(posedge HCLK) begin
        if (local_rst) begin
            state   <= ST_IDLE;
            par_cnt <= 2'd0;
            par_buf <= '0;
            sc      <= '0;
            ec      <= EC_DEF;
            sp      <= '0;
            ep      <= EP_DEF;
            cur_x   <= '0;
            cur_y   <= '0;
            id_idx  <= 3'd0;
            DISP_ON <= 1'b0;
            CMD_ERR <= 1'b0;
            px_vld  <= 1'b0;
            px_addr <= '0;
            px_dat  <= '0;
        end else begin
            CMD_ERR <= ev_err;
            px_vld  <= 1'b0;

            // Index saturates at 4, which already reads back as zero.
            if (ev_rd_rise && state == ST_RDID && id_idx != 3'd4) begin
                id_idx <= id_idx + 3'd1;
            end

            if (ev_wr && !ev_rs) begin
                // Every command abandons any half-finished parameter sequence.
                par_cnt <= 2'd0;
                state   <= ST_IDLE;
                case (ev_dat[7:0])
                    8'h01: begin
                        sc      <= '0;
                        ec      <= EC_DEF;
                        sp      <= '0;
                        ep      <= EP_DEF;
                        DISP_ON <= 1'b0;
                    end
                    8'h28: DISP_ON <= 1'b0;
                    8'h29: DISP_ON <= 1'b1;
                    8'h2A: state <= ST_CASET;
                    8'h2B: state <= ST_PASET;
                    8'h2C: begin
                        state <= ST_RAMWR;
                        cur_x <= sc;
                        cur_y <= sp;
                    end
                    8'hD3: begin
                        state  <= ST_RDID;
                        id_idx <= 3'd0;
                    end
                    default: CMD_ERR <= 1'b1;
                endcase
            end else if (ev_wr && ev_rs) begin
                case (state)
                    ST_CASET, ST_PASET: begin
                        par_buf <= {par_buf[15:0], ev_dat[7:0]};
                        par_cnt <= par_cnt + 2'd1;
                        if (par_cnt == 2'd3) begin
                            state <= ST_IDLE;
                            if (state == ST_CASET) begin
                                if (col_ok) begin
                                    sc <= p_start;
                                    ec <= p_end;
                                end else begin
                                    CMD_ERR <= 1'b1;
                                end
                            end else begin
                                if (row_ok) begin
                                    sp <= p_start;
                                    ep <= p_end;
                                end else begin
                                    CMD_ERR <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_RAMWR: begin
                        px_vld  <= 1'b1;
                        px_dat  <= ev_dat;
                        px_addr <= ADDR_W'(cur_y) * H_RES_A + ADDR_W'(cur_x);
                        if (cur_x == ec) begin
                            cur_x <= sc;
                            cur_y <= (cur_y == ep) ? sp : cur_y + 16'd1;
                        end else begin
                            cur_x <= cur_x + 16'd1;
                        end
                    end
                    default: CMD_ERR <= 1'b1;
                endcase
            end
        end
    end

    // Final register stage toward the framebuffer.
    always_ff @(posedge HCLK) begin
        if (local_rst) begin
            FB_WE    <= 1'b0;
            FB_ADDR  <= '0;
            FB_WDATA <= '0;
        end else begin
            FB_WE    <= px_vld;
            FB_ADDR  <= px_addr;
            FB_WDATA <= px_dat;
        end
    end

    // Read-ID word selected by the current index; zero in every other state.
    always_comb begin
        rd_word = '0;
        if (state == ST_RDID) begin
            case (id_idx)
                3'd2:    rd_word = {8'h00, ID_VALUE[15:8]};
                3'd3:    rd_word = {8'h00, ID_VALUE[7:0]};
                default: rd_word = '0;
            endcase
        end
    end

    assign bus.LCD_DATA_O  = rd_word;
    assign bus.LCD_DATA_OE = !cs_s && !rd_s && rst_s;

endmodule

// File: tb/tb_lcd8080_rx.sv
// Randomized bench for lcd8080_rx: a command-level panel model predicts framebuffer writes and errors.
// Latency: expected FB_WE at WR-high + 5 bench cycles, CMD_ERR at WR-high + 4.
// Backpressure: none; the host task paces every bus cycle.
module tb_lcd8080_rx;

    localparam int          H  = 240;
    localparam int          V  = 320;
    localparam int          AW = 17;
    localparam logic [15:0] ID = 16'h9341;

    localparam int M_IDLE  = 0;
    localparam int M_CASET = 1;
    localparam int M_PASET = 2;
    localparam int M_RAMWR = 3;
    localparam int M_RDID  = 4;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    lcd8080_rx_if bus ();

    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [15:0]   fb_wdata;
    logic          disp_on;
    logic          cmd_err;

    lcd8080_rx #(
        .H_RES    (H),
        .V_RES    (V),
        .ADDR_W   (AW),
        .ID_VALUE (ID)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .bus      (bus),
        .FB_WE    (fb_we),
        .FB_ADDR  (fb_addr),
        .FB_WDATA (fb_wdata),
        .DISP_ON  (disp_on),
        .CMD_ERR  (cmd_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int due;
    } pix_t;

    pix_t exp_pix[$];
    int   exp_err[$];
    pix_t mon_e;

    // Panel model, kept at command level.
    int m_sc, m_ec, m_sp, m_ep, m_x, m_y, m_mode, m_np, m_disp, m_idx;
    int m_par[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a write or an error pulse.
    always @(negedge HCLK) begin
        if (fb_we === 1'b1) begin
            if (exp_pix.size() == 0) begin
                chk("fb_we_unexpected", fb_we, 0);
            end else begin
                mon_e = exp_pix.pop_front();
                chk("fb_addr", fb_addr, mon_e.addr);
                chk("fb_wdata", fb_wdata, mon_e.data);
                chk("fb_we_cycle", cyc, mon_e.due);
            end
        end
        if (cmd_err === 1'b1) begin
            if (exp_err.size() == 0) chk("cmd_err_unexpected", cmd_err, 0);
            else chk("cmd_err_cycle", cyc, exp_err.pop_front());
        end
    end

    task automatic model_reset();
        m_sc = 0; m_ec = H - 1; m_sp = 0; m_ep = V - 1;
        m_x = 0; m_y = 0; m_mode = M_IDLE; m_np = 0; m_disp = 0; m_idx = 0;
    endtask

    function automatic int id_word(input int idx);
        if (idx == 2) return int'(ID[15:8]);
        if (idx == 3) return int'(ID[7:0]);
        return 0;
    endfunction

    task automatic model_write(input bit rs_v, input logic [15:0] d, input int hi);
        int s, e, lim;
        if (!rs_v) begin
            m_np   = 0;
            m_mode = M_IDLE;
            case (d[7:0])
                8'h01: begin m_sc = 0; m_ec = H - 1; m_sp = 0; m_ep = V - 1; m_disp = 0; end
                8'h28: m_disp = 0;
                8'h29: m_disp = 1;
                8'h2A: m_mode = M_CASET;
                8'h2B: m_mode = M_PASET;
                8'h2C: begin m_mode = M_RAMWR; m_x = m_sc; m_y = m_sp; end
                8'hD3: begin m_mode = M_RDID; m_idx = 0; end
                default: exp_err.push_back(hi + 4);
            endcase
        end else if (m_mode == M_CASET || m_mode == M_PASET) begin
            m_par[m_np] = int'(d[7:0]);
            m_np++;
            if (m_np == 4) begin
                s   = m_par[0] * 256 + m_par[1];
                e   = m_par[2] * 256 + m_par[3];
                lim = (m_mode == M_CASET) ? H : V;
                if (s <= e && e < lim) begin
                    if (m_mode == M_CASET) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end else begin
                    exp_err.push_back(hi + 4);
                end
                m_mode = M_IDLE;
                m_np   = 0;
            end
        end else if (m_mode == M_RAMWR) begin
            exp_pix.push_back('{addr: (m_y * H + m_x) % (1 << AW), data: int'(d), due: hi + 5});
            if (m_x == m_ec) begin
                m_x = m_sc;
                m_y = (m_y == m_ep) ? m_sp : m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
        end else begin
            exp_err.push_back(hi + 4);
        end
    endtask

    task automatic lcd_write(input bit cs_v, input bit rs_v, input logic [15:0] d);
        int hi;
        @(negedge HCLK);
        bus.LCD_CS     = cs_v;
        bus.LCD_RS     = rs_v;
        bus.LCD_DATA_I = d;
        bus.LCD_WR     = 1'b0;
        repeat (3) @(negedge HCLK);
        bus.LCD_WR = 1'b1;
        hi = cyc;
        if (!cs_v) model_write(rs_v, d, hi);
        repeat (5) @(negedge HCLK);
    endtask

    task automatic cmd(input logic [7:0] op);
        lcd_write(1'b0, 1'b0, {8'h00, op});
        chk("disp_on_after_cmd", disp_on, m_disp);
    endtask

    task automatic dat(input logic [15:0] d);
        lcd_write(1'b0, 1'b1, d);
    endtask

    task automatic win(input bit row, input int s, input int e);
        cmd(row ? 8'h2B : 8'h2A);
        dat(16'((s >> 8) & 255));
        dat(16'(s & 255));
        dat(16'((e >> 8) & 255));
        dat(16'(e & 255));
    endtask

    task automatic lcd_read();
        int exp_d;
        @(negedge HCLK);
        bus.LCD_CS = 1'b0;
        bus.LCD_RD = 1'b0;
        repeat (4) @(negedge HCLK);
        exp_d = (m_mode == M_RDID) ? id_word(m_idx) : 0;
        chk("rd_oe_during_rd", bus.LCD_DATA_OE, 1);
        chk("rd_data", bus.LCD_DATA_O, exp_d);
        bus.LCD_RD = 1'b1;
        if (m_mode == M_RDID && m_idx < 4) m_idx++;
        repeat (4) @(negedge HCLK);
        chk("rd_oe_after_rd", bus.LCD_DATA_OE, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] op;
        int s, e;

        bus.LCD_CS = 1'b1; bus.LCD_RS = 1'b0; bus.LCD_WR = 1'b1;
        bus.LCD_RD = 1'b1; bus.LCD_RST = 1'b1; bus.LCD_DATA_I = 16'h0000;
        model_reset();

        // Reset state
        repeat (5) @(negedge HCLK);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_wdata", fb_wdata, 0);
        chk("rst_disp_on", disp_on, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_oe", bus.LCD_DATA_OE, 0);
        chk("rst_data_o", bus.LCD_DATA_O, 0);
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);

        // Small window, five pixels wrapping back to the window origin
        win(1'b0, 0, 1);
        win(1'b1, 2, 3);
        cmd(8'h2C);
        for (int i = 0; i < 5; i++) dat(16'hF800 + 16'(i));

        // Bottom-right corner window: last framebuffer address then full-window wrap
        win(1'b0, H - 10, H - 1);
        win(1'b1, V - 10, V - 1);
        cmd(8'h2C);
        for (int i = 0; i < 101; i++) dat(16'($urandom));

        // Default window after soft reset starts at address 0
        cmd(8'h01);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) dat(16'($urandom));

        // Illegal windows are rejected and the old origin is kept
        win(1'b0, 3, 7);
        win(1'b0, 10, 5);
        win(1'b1, 0, V);
        win(1'b0, 0, H);
        cmd(8'h2C);
        dat(16'h1234);
        dat(16'h5678);

        // Read ID sequence and a read outside RDID
        cmd(8'hD3);
        for (int i = 0; i < 5; i++) lcd_read();
        cmd(8'h29);
        lcd_read();

        // Chip-select high hides all bus activity
        cmd(8'h2C);
        dat(16'hAAAA);
        lcd_write(1'b1, 1'b0, 16'h0028);
        lcd_write(1'b1, 1'b1, 16'hBBBB);
        lcd_write(1'b1, 1'b0, 16'h0055);
        chk("disp_on_cs_high", disp_on, m_disp);
        dat(16'hCCCC);

        // Truncated parameter list followed by a new command leaves the window alone
        cmd(8'h2A);
        dat(16'h0000);
        dat(16'h0020);
        cmd(8'h2C);
        dat(16'h0101);
        dat(16'h0202);

        // Panel reset in the middle of a pixel stream
        cmd(8'h2C);
        dat(16'h7777);
        @(negedge HCLK);
        bus.LCD_RST = 1'b0;
        repeat (6) @(negedge HCLK);
        chk("lcd_rst_disp_on", disp_on, 0);
        chk("lcd_rst_fb_we", fb_we, 0);
        model_reset();
        bus.LCD_RST = 1'b1;
        repeat (4) @(negedge HCLK);
        dat(16'h8888);
        dat(16'h9999);
        cmd(8'h29);
        cmd(8'h55);

        // Randomized command mix
        for (int r = 0; r < 60; r++) begin
            case ($urandom_range(0, 8))
                0: begin
                    s = $urandom_range(0, H + 8); e = $urandom_range(0, H + 8);
                    win(1'b0, s, e);
                end
                1: begin
                    s = $urandom_range(0, V + 8); e = $urandom_range(0, V + 8);
                    win(1'b1, s, e);
                end
                2: begin
                    cmd(8'h2C);
                    repeat ($urandom_range(1, 12)) dat(16'($urandom));
                end
                3: cmd($urandom_range(0, 1) ? 8'h29 : 8'h28);
                4: begin
                    op = 8'($urandom);
                    while (op inside {8'h01, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'hD3}) op = 8'($urandom);
                    cmd(op);
                end
                5: begin
                    cmd($urandom_range(0, 1) ? 8'h2A : 8'h2B);
                    repeat ($urandom_range(1, 3)) dat(16'($urandom_range(0, 1)));
                end
                6: dat(16'($urandom));
                7: begin
                    cmd(8'hD3);
                    repeat ($urandom_range(1, 5)) lcd_read();
                end
                default: lcd_write(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
            endcase
        end

        repeat (10) @(negedge HCLK);
        chk("pix_queue_drained", exp_pix.size(), 0);
        chk("err_queue_drained", exp_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
